// File: rtl/sub_bytes_seq_if.sv
// Handshake bundle for the sequential SubBytes engine: an input block channel
// (data plus direction) and an output block channel. Slave is the engine side.
interface sub_bytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_inv,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output in_inv,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes / InvSubBytes engine. A 128-bit state is captured,
// then LANES bytes per cycle are substituted in place through LANES shared
// S-box lanes. The finished block is held until the output handshake completes.
module sub_bytes_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  sub_bytes_seq_if.slave   bus,
  output logic             busy
);

  localparam int unsigned STEPS = 16 / LANES;
  localparam int unsigned CntW  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CntW-1:0] LastStep = CntW'(STEPS - 1);

  // Only divisors of 16 give a whole number of steps per block.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gen_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [127:0]    data_q, data_d;
  logic            mode_q, mode_d;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic with the AES polynomial x^8 + x^4 + x^3 + x + 1. The
  // S-box is the multiplicative inverse followed by the affine transform, which
  // reproduces the standard substitution tables exactly.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    t = gf_mul(x, x);          // x^2
    t = gf_mul(t, x);          // x^3
    t = gf_mul(t, t);          // x^6
    t = gf_mul(t, x);          // x^7
    t = gf_mul(t, t);          // x^14
    t = gf_mul(t, x);          // x^15
    t = gf_mul(t, t);          // x^30
    t = gf_mul(t, x);          // x^31
    t = gf_mul(t, t);          // x^62
    t = gf_mul(t, x);          // x^63
    t = gf_mul(t, t);          // x^126
    t = gf_mul(t, x);          // x^127
    t = gf_mul(t, t);          // x^254
    return t;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    logic [15:0] w;
    w = {a, a} << n;
    return w[15:8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [7:0] i;
    i = gf_inv(b);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    logic [7:0] t;
    t = rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
    return gf_inv(t);
  endfunction

  // ---------------------------------------------------------------------------
  // Lane datapath
  // ---------------------------------------------------------------------------
  logic [7:0] bytes_q  [16];
  logic [3:0] lane_base;
  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  // Byte view of the data register: byte 0 is the most significant byte.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      bytes_q[i] = data_q[127 - 8*i -: 8];
    end
  end

  // First byte handled by the current step.
  always_comb begin
    lane_base = 4'(int'(cnt_q) * int'(LANES));
  end

  for (genvar l = 0; l < LANES; l++) begin : gen_lane
    logic [3:0] idx;
    // Select this lane's source byte and substitute it in the chosen direction.
    always_comb begin
      idx         = lane_base + 4'(l);
      lane_in[l]  = bytes_q[idx];
      lane_out[l] = mode_q ? sbox_inv(lane_in[l]) : sbox_fwd(lane_in[l]);
    end
  end

  // ---------------------------------------------------------------------------
  // Controller: state register, next-state logic, output decode
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: one BUSY cycle per step, DONE holds until drained.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.in_valid)       state_d = StBusy;
      StBusy: if (cnt_q == LastStep)  state_d = StDone;
      StDone: if (bus.out_ready)      state_d = StIdle;
      default:                        state_d = StIdle;
    endcase
  end

  // Outputs: data is only driven in DONE so partial results stay hidden.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    busy          = 1'b0;
    unique case (state_q)
      StIdle: bus.in_ready = 1'b1;
      StBusy: busy = 1'b1;
      StDone: begin
        bus.out_valid = 1'b1;
        bus.out_data  = data_q;
        busy          = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------

  // Capture on accept; substitute LANES bytes per BUSY cycle; hold otherwise.
  always_comb begin
    data_d = data_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          data_d = bus.in_data;
          mode_d = bus.in_inv;
          cnt_d  = '0;
        end
      end
      StBusy: begin
        for (int l = 0; l < int'(LANES); l++) begin
          data_d[127 - 8*(int'(lane_base) + l) -: 8] = lane_out[l];
        end
        cnt_d = (cnt_q == LastStep) ? '0 : cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Data, mode and step counter flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq at LANES = 4, 1 and 16 with known AES vectors.
module tb_sub_bytes_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sub_bytes_seq_if if4 ();
  sub_bytes_seq_if if1 ();
  sub_bytes_seq_if if16 ();

  logic busy4, busy1, busy16;

  sub_bytes_seq #(.LANES(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4),
    .busy  (busy4)
  );

  sub_bytes_seq #(.LANES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1),
    .busy  (busy1)
  );

  sub_bytes_seq #(.LANES(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16),
    .busy  (busy16)
  );

  // Index 0: LANES=4, 1: LANES=1, 2: LANES=16.
  logic [2:0]   in_valid, in_inv, out_ready;
  logic [127:0] in_data [3];
  logic [2:0]   ov, ir, bz;
  logic [127:0] od [3];

  assign if4.in_valid   = in_valid[0];
  assign if4.in_inv     = in_inv[0];
  assign if4.in_data    = in_data[0];
  assign if4.out_ready  = out_ready[0];
  assign if1.in_valid   = in_valid[1];
  assign if1.in_inv     = in_inv[1];
  assign if1.in_data    = in_data[1];
  assign if1.out_ready  = out_ready[1];
  assign if16.in_valid  = in_valid[2];
  assign if16.in_inv    = in_inv[2];
  assign if16.in_data   = in_data[2];
  assign if16.out_ready = out_ready[2];

  assign ov = {if16.out_valid, if1.out_valid, if4.out_valid};
  assign ir = {if16.in_ready, if1.in_ready, if4.in_ready};
  assign bz = {busy16, busy1, busy4};
  assign od[0] = if4.out_data;
  assign od[1] = if1.out_data;
  assign od[2] = if16.out_data;

  localparam logic [127:0] VecA    = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;
  localparam logic [127:0] VecAs   = 128'hD42711AEE0BF98F1B8B45DE51E415230;
  localparam logic [127:0] VecB    = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] VecBs   = 128'h638293C31BFC33F5C4EEACEA4BC12816;
  localparam logic [127:0] Zero    = 128'h0;
  localparam logic [127:0] ZeroFwd = 128'h63636363636363636363636363636363;
  localparam logic [127:0] ZeroInv = 128'h52525252525252525252525252525252;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one block with out_ready high, then check latency, result and release.
  task automatic run_block(input int s, input logic [127:0] d, input logic inv,
                           input logic [127:0] exp, input int lat, input string tag);
    int cyc;
    int low;
    in_data[s]   = d;
    in_inv[s]    = inv;
    in_valid[s]  = 1'b1;
    out_ready[s] = 1'b1;
    check({tag, "_ready_before"}, 128'(ir[s]), 128'(1));
    tick();
    in_valid[s] = 1'b0;
    check({tag, "_busy"}, 128'(bz[s]), 128'(1));
    check({tag, "_hidden"}, od[s], Zero);
    low = ir[s] ? 0 : 1;
    cyc = 0;
    while (!ov[s] && cyc < 64) begin
      tick();
      cyc++;
      if (!ir[s]) low++;
    end
    check({tag, "_latency"}, 128'(cyc), 128'(lat));
    check({tag, "_data"}, od[s], exp);
    check({tag, "_ready_low"}, 128'(low), 128'(lat + 1));
    tick();
    check({tag, "_release_ready"}, 128'(ir[s]), 128'(1));
    check({tag, "_release_valid"}, 128'(ov[s]), 128'(0));
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    in_valid  = '0;
    in_inv    = '0;
    out_ready = '0;
    for (int s = 0; s < 3; s++) in_data[s] = '0;

    // Reset state on all three instances.
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      check("rst_in_ready", 128'(ir[s]), 128'(1));
      check("rst_out_valid", 128'(ov[s]), 128'(0));
      check("rst_busy", 128'(bz[s]), 128'(0));
      check("rst_out_data", od[s], Zero);
    end
    rst_n = 1'b1;
    tick();

    // LANES=4 forward, FIPS-197 round 1 vector.
    run_block(0, VecA, 1'b0, VecAs, 4, "l4_fwd");

    // Backpressure with inputs wiggling during BUSY and DONE.
    in_data[0]   = VecB;
    in_inv[0]    = 1'b0;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b0;
    tick();
    cyc = 0;
    while (!ov[0] && cyc < 64) begin
      in_inv[0]  = ~in_inv[0];
      in_data[0] = ~in_data[0];
      tick();
      cyc++;
    end
    check("bp_latency", 128'(cyc), 128'(4));
    for (int i = 0; i < 10; i++) begin
      in_inv[0]  = ~in_inv[0];
      in_data[0] = ~in_data[0];
      tick();
      check("bp_data_stable", od[0], VecBs);
      check("bp_in_ready", 128'(ir[0]), 128'(0));
      check("bp_out_valid", 128'(ov[0]), 128'(1));
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    check("bp_idle_ready", 128'(ir[0]), 128'(1));
    check("bp_idle_valid", 128'(ov[0]), 128'(0));
    check("bp_idle_data", od[0], Zero);
    check("bp_idle_busy", 128'(bz[0]), 128'(0));

    // Second block after backpressure: LANES=4 inverse.
    run_block(0, VecAs, 1'b1, VecA, 4, "l4_inv");

    // LANES=1 and LANES=16 forward.
    run_block(1, VecB, 1'b0, VecBs, 16, "l1_fwd");
    run_block(2, VecB, 1'b0, VecBs, 1, "l16_fwd");
    run_block(2, VecBs, 1'b1, VecB, 1, "l16_inv");

    // Reset two cycles into BUSY on LANES=1.
    in_data[1]   = VecB;
    in_inv[1]    = 1'b0;
    in_valid[1]  = 1'b1;
    out_ready[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    tick();
    tick();
    check("mid_busy_before", 128'(bz[1]), 128'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(ov[1]), 128'(0));
    check("mid_rst_in_ready", 128'(ir[1]), 128'(1));
    check("mid_rst_busy", 128'(bz[1]), 128'(0));
    check("mid_rst_out_data", od[1], Zero);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_still_idle", 128'(ov[1]), 128'(0));

    run_block(1, Zero, 1'b0, ZeroFwd, 16, "l1_zero_fwd");
    run_block(1, Zero, 1'b1, ZeroInv, 16, "l1_zero_inv");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
- Sequential, parametrised AES SubBytes / InvSubBytes engine for the 128-bit AES state.
- Substitutes LANES bytes per clock through LANES shared S-box instances, so area can be traded against latency.
- Encrypt or decrypt direction is selected per block.
- Sits between AddRoundKey and ShiftRows in the round datapath, with valid/ready handshakes on both sides.

Parameters:
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- STEPS, 16/LANES, derived localparam (not overridable); BUSY cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data/in_inv valid
- in_ready  output  1  engine can accept a block
- in_data  input  128  state; byte 0 = in_data[127:120], byte 15 = in_data[7:0]
- in_inv  input  1  0 = forward S-box (encrypt), 1 = inverse S-box (decrypt)
- out_valid  output  1  out_data holds a completed block
- out_ready  input  1  downstream accepts out_data
- out_data  output  128  substituted state, same byte order as in_data
- busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; step counter = 0; data register = 0; mode register = 0.
  - in_ready = 1 after reset; out_valid = 0; busy = 0; out_data = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge: data register <= in_data; mode register <= in_inv; counter <= 0; next state BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle, bytes counter*LANES through counter*LANES+LANES-1 of the data register are replaced with S(b), or InvS(b) when the mode register is 1.
  - All other bytes are held.
  - counter increments each cycle.
  - On the cycle processing counter = STEPS-1: next state DONE; counter wraps to 0.
- DONE:
  - out_valid = 1; out_data = data register.
  - Data is stable while out_ready = 0; no bytes change.
  - On out_valid & out_ready at an edge: next state IDLE.
- Latency:
  - Accept edge T → out_valid first high after edge T+STEPS.
  - LANES=16: 1 BUSY cycle; LANES=1: 16 BUSY cycles.
  - Minimum accept-to-accept period: STEPS+2 cycles.
  - in_ready and out_valid are never high together; no same-cycle accept on release.
- Inputs are ignored outside IDLE:
  - in_valid and in_inv changes during BUSY/DONE have no effect.
  - The mode is fixed for the whole block.
- out_data is 0 in IDLE and BUSY, so partial results are never exposed.
- S-box and inverse S-box are the FIPS-197 tables, combinational. Each lane selects forward or inverse output with the mode register. There are no extra pipeline stages.
- rst_n asserted mid-block (BUSY or DONE): block discarded, all registers return to reset values immediately. No output handshake completes for the discarded block.
- out_ready high while not out_valid: ignored.

Test Plan:
- LANES=4, forward: in_data=193DE3BEA0F4E22B9AC68D2AE9F84808, in_inv=0, out_ready=1 → out_valid high 4 edges after accept; out_data=D42711AEE0BF98F1B8B45DE51E415230; in_ready low for exactly 5 cycles.
- LANES=4, inverse: in_data=D42711AEE0BF98F1B8B45DE51E415230, in_inv=1 → out_data=193DE3BEA0F4E22B9AC68D2AE9F84808.
- LANES=1 and LANES=16, forward: in_data=00112233445566778899AABBCCDDEEFF → out_data=638293C31BFC33F5C4EEACEA4BC12816; latency 16 and 1 respectively.
- Backpressure and mode change: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and in_inv toggling → out_data stable, in_ready=0, no second accept. Release out_ready → IDLE next cycle, then a second block is accepted correctly.
- Reset mid-operation: assert rst_n=0 two cycles into BUSY (LANES=1) → out_valid=0, in_ready=1, busy=0, out_data=0 immediately. A subsequent block with in_data=0 gives out_data=63636363636363636363636363636363 and, with in_inv=1, gives 52525252525252525252525252525252.
